// File: rtl/mips_perf_pkg.sv
// Shared types and constants for the MIPS performance monitor.
// Used by mips_perf_counter and mips_perf_monitor.
package mips_perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } perf_state_e;

    localparam int NUM_CNT = 10;

    localparam logic [3:0] PERF_ADDR_PC     = 4'd8;
    localparam logic [3:0] PERF_ADDR_CYC    = 4'd9;
    localparam logic [3:0] PERF_ADDR_STATUS = 4'd10;

endpackage

// File: rtl/mips_perf_counter.sv
// Single free-running modulo-2^CNT_W counter with synchronous clear.
// wrap flags the increment that rolls all-ones over to zero.
module mips_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = inc && (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_perf_monitor.sv
// Performance monitor: counts core event strobes, PC updates and RUN cycles,
// with a req/ack read port. Optional sticky overflow flags: MIPS_PERF_OVF_IRQ_EN.
module mips_perf_monitor
    import mips_perf_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int NUM_EV = 8
) (
    input  logic              mips_cpu_clk,
    input  logic              mips_cpu_reset_n,
    input  logic              mips_cpu_pc_sig,
    input  logic [NUM_EV-1:0] mips_cpu_perf_sig,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              ctrl_clear,
    input  logic              rd_req,
    input  logic [3:0]        rd_addr,
    output logic              rd_ack,
    output logic [CNT_W-1:0]  rd_data,
    output logic              mon_running,
    output logic              ovf_irq
);

    perf_state_e        state;
    logic               pc_sig_p1;
    logic [NUM_EV-1:0]  perf_sig_p1;
    logic               cnt_en;
    logic [NUM_CNT-1:0] inc_vec;
    logic [NUM_CNT-1:0] wrap_vec;
    logic [NUM_CNT-1:0] flags_view;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [CNT_W-1:0]   rd_mux;
    logic [CNT_W+NUM_CNT:0] status_wide;

    // Stage p1: input strobes registered once before counting
    always_ff @(posedge mips_cpu_clk) begin
        pc_sig_p1   <= mips_cpu_pc_sig;
        perf_sig_p1 <= mips_cpu_perf_sig;
    end

    // A stop or clear on the count edge drops whatever sits in the p1 register
    assign cnt_en = (state == RUN) && !ctrl_stop && !ctrl_clear;

    always_comb begin
        inc_vec                = '0;
        inc_vec[NUM_EV-1:0]    = perf_sig_p1 & {NUM_EV{cnt_en}};
        inc_vec[PERF_ADDR_PC]  = pc_sig_p1 && cnt_en;
        inc_vec[PERF_ADDR_CYC] = cnt_en;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        mips_perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (mips_cpu_clk),
            .rst_n (mips_cpu_reset_n),
            .clr   (ctrl_clear),
            .inc   (inc_vec[i]),
            .cnt   (cnt[i]),
            .wrap  (wrap_vec[i])
        );
    end

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            state       <= IDLE;
            mon_running <= 1'b0;
        end else if (ctrl_clear) begin
            state       <= IDLE;
            mon_running <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ctrl_stop) begin
                        state       <= HOLD;
                        mon_running <= 1'b0;
                    end
                end
                IDLE, HOLD: begin
                    if (ctrl_start && !ctrl_stop) begin
                        state       <= RUN;
                        mon_running <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mon_running <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIPS_PERF_OVF_IRQ_EN
    logic [NUM_CNT-1:0] ovf_flags;

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            ovf_flags <= '0;
            ovf_irq   <= 1'b0;
        end else if (ctrl_clear) begin
            ovf_flags <= '0;
            ovf_irq   <= 1'b0;
        end else begin
            ovf_flags <= ovf_flags | wrap_vec;
            ovf_irq   <= |ovf_flags;
        end
    end

    assign flags_view = ovf_flags;
`else
    logic unused_wrap;
    assign unused_wrap = ^wrap_vec;
    assign flags_view  = '0;
    assign ovf_irq     = 1'b0;
`endif

    // Status word is zero-extended, then truncated when CNT_W is narrower than 11
    assign status_wide = {{CNT_W{1'b0}}, flags_view, mon_running};

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_addr == 4'(i)) begin
                rd_mux = cnt[i];
            end
        end
        if (rd_addr == PERF_ADDR_STATUS) begin
            rd_mux = status_wide[CNT_W-1:0];
        end
    end

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack <= rd_req && !rd_ack;
            if (rd_req && !rd_ack) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_mips_perf_monitor.sv
// Directed bench for mips_perf_monitor built with 4-bit counters so wraps are reachable.
// Expectations follow MIPS_PERF_OVF_IRQ_EN when that macro is defined.
module tb_mips_perf_monitor;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pc_sig = 1'b0;
    logic [7:0]       perf_sig = 8'h00;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clear = 1'b0;
    logic             rd_req = 1'b0;
    logic [3:0]       rd_addr = 4'd0;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;
    logic             mon_running;
    logic             ovf_irq;

    int errors = 0;
    int checks = 0;

    mips_perf_monitor #(.CNT_W(CNT_W), .NUM_EV(8)) dut (
        .mips_cpu_clk      (clk),
        .mips_cpu_reset_n  (rst_n),
        .mips_cpu_pc_sig   (pc_sig),
        .mips_cpu_perf_sig (perf_sig),
        .ctrl_start        (start),
        .ctrl_stop         (stop),
        .ctrl_clear        (clear),
        .rd_req            (rd_req),
        .rd_addr           (rd_addr),
        .rd_ack            (rd_ack),
        .rd_data           (rd_data),
        .mon_running       (mon_running),
        .ovf_irq           (ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a single read; returns ack/data after the accepting edge and ack one cycle later.
    task automatic do_read(input logic [3:0] a, output logic ack1,
                           output logic [CNT_W-1:0] d, output logic ack2);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req = 1'b0;
        ack1 = rd_ack;
        d    = rd_data;
        tick();
        ack2 = rd_ack;
    endtask

    task automatic test_reset();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({rd_ack, rd_data, mon_running, ovf_irq} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b data=%0d run=%b irq=%b expected all 0",
                     rd_ack, rd_data, mon_running, ovf_irq);
        end
        rst_n = 1'b1;
        tick();
        for (int a = 0; a <= 10; a++) begin
            do_read(4'(a), a1, d, a2);
            checks++;
            if (a1 !== 1'b1 || d !== 4'd0 || a2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_read addr%0d: ack=%b data=%0d ack_next=%b expected 1,0,0",
                         a, a1, d, a2);
            end
        end
    endtask

    task automatic test_counting();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        logic [3:0] addrs [8] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd12, 4'd15};
        logic [CNT_W-1:0] exps [8] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd3, 4'd6, 4'd0, 4'd0};
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (mon_running !== 1'b1) begin
            errors++;
            $display("FAIL start_running: mon_running=%b expected 1", mon_running);
        end
        for (int i = 0; i < 5; i++) begin
            perf_sig = 8'h01;
            pc_sig   = (i < 3);
            tick();
        end
        perf_sig = 8'h00;
        pc_sig   = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (mon_running !== 1'b0) begin
            errors++;
            $display("FAIL stop_running: mon_running=%b expected 0", mon_running);
        end
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            do_read(addrs[k], a1, d, a2);
            checks++;
            if (a1 !== 1'b1 || d !== exps[k]) begin
                errors++;
                $display("FAIL count_addr%0d: ack=%b data=%0d expected ack=1 data=%0d",
                         addrs[k], a1, d, exps[k]);
            end
        end
        repeat (4) tick();
        do_read(4'd9, a1, d, a2);
        checks++;
        if (d !== 4'd6) begin
            errors++;
            $display("FAIL hold_cycles: data=%0d expected 6", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] exp_d [5] = '{4'd5, 4'd5, 4'd3, 4'd3, 4'd6};
        logic             exp_a [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]       addr_seq [5] = '{4'd0, 4'd8, 4'd8, 4'd9, 4'd9};
        rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_addr = addr_seq[i];
            tick();
            checks++;
            if (rd_ack !== exp_a[i] || rd_data !== exp_d[i]) begin
                errors++;
                $display("FAIL b2b_step%0d: ack=%b data=%0d expected ack=%b data=%0d",
                         i, rd_ack, rd_data, exp_a[i], exp_d[i]);
            end
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 4'd6) begin
            errors++;
            $display("FAIL b2b_hold: ack=%b data=%0d expected ack=0 data=6", rd_ack, rd_data);
        end
    endtask

    task automatic test_start_stop_clear();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        start = 1'b1; stop = 1'b1;
        tick();
        checks++;
        if (mon_running !== 1'b0) begin
            errors++;
            $display("FAIL hold_start_stop: mon_running=%b expected 0", mon_running);
        end
        stop = 1'b0;
        tick();
        checks++;
        if (mon_running !== 1'b1) begin
            errors++;
            $display("FAIL resume: mon_running=%b expected 1", mon_running);
        end
        stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (mon_running !== 1'b0) begin
            errors++;
            $display("FAIL run_start_stop: mon_running=%b expected 0", mon_running);
        end
        do_read(4'd9, a1, d, a2);
        checks++;
        if (d !== 4'd6) begin
            errors++;
            $display("FAIL cycles_after_resume: data=%0d expected 6", d);
        end
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (mon_running !== 1'b0) begin
            errors++;
            $display("FAIL clear_start: mon_running=%b expected 0", mon_running);
        end
        for (int a = 8; a <= 10; a++) begin
            do_read(4'(a), a1, d, a2);
            checks++;
            if (d !== 4'd0) begin
                errors++;
                $display("FAIL cleared_addr%0d: data=%0d expected 0", a, d);
            end
        end
        do_read(4'd0, a1, d, a2);
        checks++;
        if (d !== 4'd0) begin
            errors++;
            $display("FAIL cleared_addr0: data=%0d expected 0", d);
        end
    endtask

    task automatic test_wrap();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] exp_status;
        logic             exp_irq;
`ifdef MIPS_PERF_OVF_IRQ_EN
        exp_status = 4'b1000;
        exp_irq    = 1'b1;
`else
        exp_status = 4'b0000;
        exp_irq    = 1'b0;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        perf_sig = 8'h04;
        repeat (16) tick();
        perf_sig = 8'h00;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();
        do_read(4'd2, a1, d, a2);
        checks++;
        if (d !== 4'd0) begin
            errors++;
            $display("FAIL wrap_addr2: data=%0d expected 0", d);
        end
        do_read(4'd9, a1, d, a2);
        checks++;
        if (d !== 4'd1) begin
            errors++;
            $display("FAIL wrap_cycles: data=%0d expected 1", d);
        end
        do_read(4'd10, a1, d, a2);
        checks++;
        if (d !== exp_status) begin
            errors++;
            $display("FAIL wrap_status: data=%b expected %b", d, exp_status);
        end
        checks++;
        if (ovf_irq !== exp_irq) begin
            errors++;
            $display("FAIL wrap_irq: ovf_irq=%b expected %b", ovf_irq, exp_irq);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        checks++;
        if (ovf_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_clear: ovf_irq=%b expected 0", ovf_irq);
        end
        do_read(4'd10, a1, d, a2);
        checks++;
        if (d !== 4'd0) begin
            errors++;
            $display("FAIL status_after_clear: data=%b expected 0000", d);
        end
    endtask

    task automatic test_reset_mid();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        start = 1'b1;
        tick();
        start = 1'b0;
        perf_sig = 8'h01;
        pc_sig   = 1'b1;
        repeat (3) tick();
        perf_sig = 8'h00;
        pc_sig   = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd0;
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || rd_data !== 4'd2 || mon_running !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_read: ack=%b data=%0d run=%b expected 1,2,1",
                     rd_ack, rd_data, mon_running);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_ack !== 1'b0 || rd_data !== 4'd0 || mon_running !== 1'b0 || ovf_irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ack=%b data=%0d run=%b irq=%b expected all 0",
                     rd_ack, rd_data, mon_running, ovf_irq);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int a = 8; a <= 9; a++) begin
            do_read(4'(a), a1, d, a2);
            checks++;
            if (a1 !== 1'b1 || d !== 4'd0) begin
                errors++;
                $display("FAIL post_reset_addr%0d: ack=%b data=%0d expected ack=1 data=0",
                         a, a1, d);
            end
        end
        do_read(4'd0, a1, d, a2);
        checks++;
        if (d !== 4'd0 || mon_running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_addr0: data=%0d run=%b expected 0,0", d, mon_running);
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_back_to_back();
        test_start_stop_clear();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_perf_monitor.md
# mips_perf_monitor

Performance-monitor stage sitting directly downstream of `mips_cpu_top`. It consumes the core's `mips_cpu_pc_sig` strobe and 8-bit `mips_cpu_perf_sig` event bus and accumulates them into per-event counters, a PC-update counter and a cycle counter. A simple request/acknowledge read port exposes the counters to the test harness or a debug host. Start, stop and clear commands control counting.

## Interface
- `CNT_W`, 32: width of every counter and of `rd_data`.
- `NUM_EV`, 8: number of event strobes; must match the `mips_cpu_perf_sig` width.
- `mips_cpu_clk`  in  1  single clock; all logic is rising-edge.
- `mips_cpu_reset_n`  in  1  asynchronous, active-low reset.
- `mips_cpu_pc_sig`  in  1  one-cycle pulse per PC update from the core.
- `mips_cpu_perf_sig`  in  NUM_EV  per-bit one-cycle event strobes from the core.
- `ctrl_start`  in  1  start/resume counting (pulse).
- `ctrl_stop`  in  1  freeze counting (pulse).
- `ctrl_clear`  in  1  zero all counters and flags, return to IDLE (pulse).
- `rd_req`  in  1  read request.
- `rd_addr`  in  4  counter select.
- `rd_ack`  out  1  read data valid, one cycle wide.
- `rd_data`  out  CNT_W  read data.
- `mon_running`  out  1  high while in RUN.
- `ovf_irq`  out  1  OR of sticky overflow flags.

## Operation
- Input stage: `mips_cpu_pc_sig` and `mips_cpu_perf_sig` are registered once before counting. An event at cycle N updates its counter at the edge ending cycle N+1.
- States and transitions:
  - Reset enters IDLE.
  - IDLE --start--> RUN.
  - RUN --stop--> HOLD.
  - HOLD --start--> RUN.
  - Clear in any state zeroes all counters and flags and goes to IDLE.
- Command priority: clear > stop > start.
  - start and stop together in RUN: go to HOLD.
  - start and stop together in IDLE/HOLD: no change.
- Counting happens only in RUN. IDLE and HOLD retain values.
  - Event counter i increments by 1 when registered bit i is 1.
  - PC counter increments on a registered `pc_sig`.
  - Cycle counter increments every RUN cycle.
- Arithmetic: unsigned, modulo 2^CNT_W. All-ones + 1 wraps to 0.
- Events already in the input register when stop arrives are dropped. Events in flight when start arrives are counted only if the state is RUN at their count edge.
- Address map:
  - 0..7: event counters 0..7.
  - 8: PC counter.
  - 9: cycle counter.
  - 10: status, {overflow flags[9:0], mon_running} in bits [10:0], upper bits 0.
  - 11..15: read 0.

## Timing
- Reset values: all counters 0, `rd_ack` 0, `rd_data` 0, `mon_running` 0, `ovf_irq` 0, state IDLE.
- Read request: `rd_req` is accepted on an edge where `rd_ack` is 0.
  - On the following edge, `rd_ack` goes to 1 for exactly one cycle.
  - `rd_data` carries the selected value as it stood before the accepting edge's increment.
- `rd_req` is ignored while `rd_ack` is 1. Back-to-back reads complete at most one per 2 cycles.
- `rd_data` holds its last value after `rd_ack` falls.
- A read accepted on the same edge as `ctrl_clear` returns the pre-clear value.
- `mon_running` is registered. It rises the cycle after start is sampled in IDLE/HOLD.
- Asserting reset mid-read aborts the read: `rd_ack` is forced to 0 immediately, asynchronously.

## Configuration
- Macro: `MIPS_PERF_OVF_IRQ_EN`.
- Defined:
  - Each of the 10 counters has a sticky overflow flag, set on a wrap from all-ones to 0.
  - Flags are cleared only by `ctrl_clear` or reset.
  - `ovf_irq` is the registered OR of the flags.
  - The status word reports the flags.
- Undefined: no flag storage, `ovf_irq` tied 0, status bits [10:1] read 0. The port list is identical in both builds.

## Structure
- Package `mips_perf_pkg`:
  - state enum (IDLE, RUN, HOLD).
  - `NUM_CNT` = 10.
  - address constants `PERF_ADDR_PC` = 8, `PERF_ADDR_CYC` = 9, `PERF_ADDR_STATUS` = 10.
- Sub-module `mips_perf_counter`: one CNT_W counter with inc, clear and wrap outputs, instantiated 10 times.
- Read mux and state machine live in the top.

## Test plan
- Reset, then read addresses 0..10 → every `rd_data` is 0, each `rd_ack` one cycle wide, status 0.
- Start, drive `perf_sig`=8'h01 for 5 cycles and `pc_sig` for 3 cycles, stop, wait 4 cycles → addr0=5, addr8=3, other events 0, addr9 = cycles in RUN, unchanged across HOLD.
- Start and stop in the same cycle while in RUN, then clear together with start → first gives HOLD; second gives IDLE with all counters 0 and `mon_running`=0.
- Hold `rd_req` high continuously → `rd_ack` pattern 0,1,0,1; address changes take effect only on accepting edges.
- Preload via `CNT_W`=4, feed 16 events on bit 2 → addr2=0. With the macro: status bit 3 = 1 and `ovf_irq`=1 until clear. Without the macro: `ovf_irq`=0.
- Assert reset during `rd_ack` and mid-RUN → outputs return to reset values immediately; no count survives.
